bitserial_logic_unit: RTL

//   Parametrised, sequential successor to the single-bit NAND-derived gate set.

---
 rtl/bitserial_logic_unit.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/bitserial_logic_unit.sv
// Bit-serial bitwise logic unit: applies one of eight logic ops BITS_PER_CYCLE bits per clock.
// Optional zero/parity result flags are built in when the BLU_FLAGS_EN macro is defined.
module bitserial_logic_unit #(
   parameter int WIDTH          = 8,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] y
`ifdef BLU_FLAGS_EN
   ,
   output logic             zero,
   output logic             parity
`endif
);

   localparam int BPC   = BITS_PER_CYCLE;
   localparam int STEPS = WIDTH / BPC;
   localparam int CW    = $clog2(STEPS) + 1;

   generate
      if ((WIDTH < 1) || (BPC < 1) || ((WIDTH % BPC) != 0)) begin : g_bad_params
         $error("bitserial_logic_unit: BITS_PER_CYCLE must be >= 1 and divide WIDTH");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            state_r;
   state_t            state_next_s;
   logic              accept_s;
   logic              last_s;
   logic              busy_r;
   logic              done_r;
   logic [2:0]        op_r;
   logic [CW-1:0]     count_r;
   logic [WIDTH-1:0]  a_sh_r;
   logic [WIDTH-1:0]  b_sh_r;
   logic [WIDTH-1:0]  res_sh_r;
   logic [WIDTH-1:0]  y_r;
   logic [BPC-1:0]    slice_s;
   logic [WIDTH-1:0]  res_next_s;

   function automatic logic [BPC-1:0] apply_op(input logic [2:0] f,
                                               input logic [BPC-1:0] x,
                                               input logic [BPC-1:0] w);
      case (f)
         3'b000:  return x & w;
         3'b001:  return x | w;
         3'b010:  return x ^ w;
         3'b011:  return ~(x & w);
         3'b100:  return ~(x | w);
         3'b101:  return ~(x ^ w);
         3'b110:  return ~x;
         default: return x;
      endcase
   endfunction

   function automatic logic xor_reduce(input logic [WIDTH-1:0] v);
      return ^v;
   endfunction

   // Next-state decode; accept_s marks an operand capture, last_s the final step
   always_comb begin
      state_next_s = state_r;
      accept_s     = 1'b0;
      last_s       = 1'b0;
      case (state_r)
         S_IDLE: begin
            if (start) begin
               state_next_s = S_RUN;
               accept_s     = 1'b1;
            end else begin
               state_next_s = S_IDLE;
            end
         end
         S_RUN: begin
            if (count_r == CW'(STEPS - 1)) begin
               state_next_s = S_DONE;
               last_s       = 1'b1;
            end else begin
               state_next_s = S_RUN;
            end
         end
         S_DONE: begin
            if (start) begin
               state_next_s = S_RUN;
               accept_s     = 1'b1;
            end else begin
               state_next_s = S_IDLE;
            end
         end
         default: state_next_s = S_IDLE;
      endcase
   end

   // Current slice result, inserted at the MSB end so the LSB slice lands lowest after STEPS shifts
   always_comb begin
      slice_s    = apply_op(op_r, a_sh_r[BPC-1:0], b_sh_r[BPC-1:0]);
      res_next_s = (res_sh_r >> BPC) | (WIDTH'(slice_s) << (WIDTH - BPC));
   end

   // State register and registered handshake outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= S_IDLE;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_next_s;
         busy_r  <= (state_next_s == S_RUN);
         done_r  <= last_s;
      end
   end

   // Operand/result shift datapath and step counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_r     <= 3'b000;
         count_r  <= '0;
         a_sh_r   <= '0;
         b_sh_r   <= '0;
         res_sh_r <= '0;
      end else if (accept_s) begin
         op_r     <= op;
         count_r  <= '0;
         a_sh_r   <= a;
         b_sh_r   <= b;
         res_sh_r <= '0;
      end else if (state_r == S_RUN) begin
         count_r  <= count_r + CW'(1);
         a_sh_r   <= a_sh_r >> BPC;
         b_sh_r   <= b_sh_r >> BPC;
         res_sh_r <= res_next_s;
      end else begin
         count_r  <= count_r;
      end
   end

   // Visible result: only updated on the edge that completes the last step
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y_r <= '0;
      end else if (last_s) begin
         y_r <= res_next_s;
      end else begin
         y_r <= y_r;
      end
   end

   assign busy = busy_r;
   assign done = done_r;
   assign y    = y_r;

`ifdef BLU_FLAGS_EN
   logic zero_r;
   logic parity_r;

   // Result flags, captured alongside y
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         zero_r   <= 1'b1;
         parity_r <= 1'b0;
      end else if (last_s) begin
         zero_r   <= (res_next_s == '0);
         parity_r <= xor_reduce(res_next_s);
      end else begin
         zero_r   <= zero_r;
         parity_r <= parity_r;
      end
   end

   assign zero   = zero_r;
   assign parity = parity_r;
`endif

endmodule
